// File: rtl/objects_line_fetcher.sv
// objects_line_fetcher
//   Read-side client of the 256x32 object ROM. On each line_start strobe the
//   next scanline and all object positions are latched, then one 32-bit row
//   per object (player, enemy, bullet) is fetched into a row buffer. During
//   active video the buffers are serialised against pixel_x to produce
//   registered per-object pixel flags.
//
// Ports
//   clk, reset           : pixel clock, asynchronous active-low reset
//   line_start, next_y   : hblank strobe and the scanline to fetch for
//   pixel_x, video_on    : current column and active-video qualifier
//   player_x/y           : player top-left (player is always enabled)
//   enemy_x/y, enemy_en  : enemy top-left and visibility
//   bullet_x/y, bullet_en: bullet top-left and visibility
//   rom_addr, rom_data   : object ROM interface (data valid one clk after addr)
//   pix_on               : {bullet, enemy, player} pixel flags, registered
//   busy, fetch_done     : fetch in progress / one-cycle completion pulse
module objects_line_fetcher #(
    parameter logic [7:0] PLAYER_BASE = 8'h00,
    parameter logic [7:0] ENEMY_BASE  = 8'h20,
    parameter logic [7:0] BULLET_BASE = 8'h40,
    parameter int         BULLET_ROWS = 7,
    parameter int         SPR_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             line_start,
    input  logic [9:0]       next_y,
    input  logic [9:0]       pixel_x,
    input  logic             video_on,
    input  logic [9:0]       player_x,
    input  logic [9:0]       player_y,
    input  logic [9:0]       enemy_x,
    input  logic [9:0]       enemy_y,
    input  logic             enemy_en,
    input  logic [9:0]       bullet_x,
    input  logic [9:0]       bullet_y,
    input  logic             bullet_en,
    output logic [7:0]       rom_addr,
    input  logic [SPR_W-1:0] rom_data,
    output logic [2:0]       pix_on,
    output logic             busy,
    output logic             fetch_done
);

    typedef enum logic [2:0] {
        IDLE, ADDR_P, DATA_P, ADDR_E, DATA_E, ADDR_B, DATA_B, DONE
    } state_t;

    state_t           state_q, state_d;
    logic [9:0]       y_q, y_d;
    logic [9:0]       px_q, px_d, py_q, py_d;
    logic [9:0]       ex_q, ex_d, ey_q, ey_d;
    logic [9:0]       bx_q, bx_d, by_q, by_d;
    logic             een_q, een_d, ben_q, ben_d;
    logic [SPR_W-1:0] buf_p_q, buf_p_d, buf_e_q, buf_e_d, buf_b_q, buf_b_d;
    logic [7:0]       rom_addr_q, rom_addr_d;
    logic [2:0]       pix_on_q, pix_on_d;
    logic             busy_q, busy_d, fetch_done_q, fetch_done_d;

    // Unsigned 10-bit operands subtracted into an 11-bit two's-complement result.
    function automatic logic [10:0] diff11(input logic [9:0] a, input logic [9:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    function automatic logic in_range(input logic [10:0] row, input logic [10:0] h,
                                      input logic en);
        return en && !row[10] && (row < h);
    endfunction

    // Column hit: the column must fall inside the sprite; bit SPR_W-1 is the leftmost pixel.
    function automatic logic col_hit(input logic [10:0] col, input logic [SPR_W-1:0] row_buf);
        logic [4:0] idx;
        idx = 5'(SPR_W - 1) - col[4:0];
        return (col < 11'(SPR_W)) && row_buf[idx];
    endfunction

    logic [10:0] row_p, row_e, row_b, row_p_new;
    assign row_p     = diff11(y_q, py_q);
    assign row_e     = diff11(y_q, ey_q);
    assign row_b     = diff11(y_q, by_q);
    // The player address is issued in the same edge that latches the inputs,
    // so it is computed straight from the live inputs.
    assign row_p_new = diff11(next_y, player_y);

    // NOTE: every signal assigned here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        y_d          = y_q;
        px_d         = px_q;
        py_d         = py_q;
        ex_d         = ex_q;
        ey_d         = ey_q;
        bx_d         = bx_q;
        by_d         = by_q;
        een_d        = een_q;
        ben_d        = ben_q;
        buf_p_d      = buf_p_q;
        buf_e_d      = buf_e_q;
        buf_b_d      = buf_b_q;
        rom_addr_d   = rom_addr_q;
        fetch_done_d = 1'b0;

        if (line_start) begin
            // A strobe in any state, including mid-fetch, relatches and restarts.
            y_d        = next_y;
            px_d       = player_x;
            py_d       = player_y;
            ex_d       = enemy_x;
            ey_d       = enemy_y;
            een_d      = enemy_en;
            bx_d       = bullet_x;
            by_d       = bullet_y;
            ben_d      = bullet_en;
            rom_addr_d = PLAYER_BASE + {3'b000, row_p_new[4:0]};
            state_d    = ADDR_P;
        end else begin
            case (state_q)
                IDLE:   state_d = IDLE;
                ADDR_P: state_d = DATA_P;
                DATA_P: begin
                    buf_p_d    = in_range(row_p, 11'(SPR_W), 1'b1) ? rom_data : '0;
                    rom_addr_d = ENEMY_BASE + {3'b000, row_e[4:0]};
                    state_d    = ADDR_E;
                end
                ADDR_E: state_d = DATA_E;
                DATA_E: begin
                    buf_e_d    = in_range(row_e, 11'(SPR_W), een_q) ? rom_data : '0;
                    rom_addr_d = BULLET_BASE + {3'b000, row_b[4:0]};
                    state_d    = ADDR_B;
                end
                ADDR_B: state_d = DATA_B;
                DATA_B: begin
                    buf_b_d      = in_range(row_b, 11'(BULLET_ROWS), ben_q) ? rom_data : '0;
                    fetch_done_d = 1'b1;
                    state_d      = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        busy_d   = (state_d != IDLE);
        pix_on_d = {video_on && col_hit(diff11(pixel_x, bx_q), buf_b_q),
                    video_on && col_hit(diff11(pixel_x, ex_q), buf_e_q),
                    video_on && col_hit(diff11(pixel_x, px_q), buf_p_q)};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            y_q          <= '0;
            px_q         <= '0;
            py_q         <= '0;
            ex_q         <= '0;
            ey_q         <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            een_q        <= 1'b0;
            ben_q        <= 1'b0;
            buf_p_q      <= '0;
            buf_e_q      <= '0;
            buf_b_q      <= '0;
            rom_addr_q   <= '0;
            pix_on_q     <= '0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            px_q         <= px_d;
            py_q         <= py_d;
            ex_q         <= ex_d;
            ey_q         <= ey_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            een_q        <= een_d;
            ben_q        <= ben_d;
            buf_p_q      <= buf_p_d;
            buf_e_q      <= buf_e_d;
            buf_b_q      <= buf_b_d;
            rom_addr_q   <= rom_addr_d;
            pix_on_q     <= pix_on_d;
            busy_q       <= busy_d;
            fetch_done_q <= fetch_done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign pix_on     = pix_on_q;
    assign busy       = busy_q;
    assign fetch_done = fetch_done_q;

endmodule

// File: tb/tb_objects_line_fetcher.sv
// Testbench for objects_line_fetcher: a synchronous-read ROM model feeds the
// DUT; a behavioural model of latched positions and row buffers predicts
// pix_on every cycle, and directed fetches check the strobe/ROM timing.
module tb_objects_line_fetcher;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        line_start = 1'b0;
    logic [9:0]  next_y = '0, pixel_x = '0;
    logic        video_on = 1'b0;
    logic [9:0]  player_x = '0, player_y = '0;
    logic [9:0]  enemy_x = '0, enemy_y = '0;
    logic        enemy_en = 1'b0;
    logic [9:0]  bullet_x = '0, bullet_y = '0;
    logic        bullet_en = 1'b0;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data = '0;
    logic [2:0]  pix_on;
    logic        busy, fetch_done;

    always #5 clk = ~clk;

    objects_line_fetcher dut (
        .clk(clk), .reset(reset), .line_start(line_start), .next_y(next_y),
        .pixel_x(pixel_x), .video_on(video_on),
        .player_x(player_x), .player_y(player_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_en(enemy_en),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_en(bullet_en),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .pix_on(pix_on), .busy(busy), .fetch_done(fetch_done)
    );

    // Object ROM: synchronous read, data one clock after the address.
    logic [31:0] rom [256];
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = (32'(i) * 32'h9E3779B1) ^ 32'hC3A5_0F1E;
        rom[8'h0F] = 32'h03BF_FDC0;
        rom[8'h20] = 32'h000E_7000;
        rom[8'h46] = 32'h0001_8000;
    end
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Model state: positions/buffers as they should be after the last complete fetch.
    int          lat_x [3];
    logic [31:0] mbuf [3];
    bit          model_valid = 1'b0;
    logic [7:0]  seen_addr [3];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] model_row(int ny, int oy, int h, int base, bit en);
        int r;
        r = ny - oy;
        if (en && r >= 0 && r < h) return rom[base + r];
        return 32'h0;
    endfunction

    function automatic logic [7:0] model_addr(int ny, int oy, int base);
        return 8'(base + ((ny - oy) & 31));
    endfunction

    function automatic logic [2:0] model_pix(int x, bit von);
        logic [2:0] r;
        int col;
        r = '0;
        for (int k = 0; k < 3; k++) begin
            col = x - lat_x[k];
            if (von && col >= 0 && col < 32 && mbuf[k][31 - col]) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Compare process: expectation from the inputs seen at the edge, checked half a cycle later.
    initial begin
        logic [2:0] e;
        bit v;
        forever begin
            @(posedge clk);
            e = model_pix(int'(pixel_x), video_on);
            v = model_valid;
            @(negedge clk);
            if (v) check("pix_on", {29'b0, pix_on}, {29'b0, e});
        end
    end

    // One full fetch; optionally preceded by a decoy strobe that gets aborted.
    task automatic do_fetch(input int ny, input int px, input int py, input int ex,
                            input int ey, input bit een, input int bx, input int by,
                            input bit ben, input int decoy_cycles, input int decoy_ny);
        @(negedge clk);
        model_valid = 1'b0;
        player_x = 10'(px); player_y = 10'(py);
        enemy_x = 10'(ex);  enemy_y = 10'(ey);  enemy_en = een;
        bullet_x = 10'(bx); bullet_y = 10'(by); bullet_en = ben;
        if (decoy_cycles > 0) begin
            next_y = 10'(decoy_ny);
            line_start = 1'b1;
            for (int i = 1; i <= decoy_cycles; i++) begin
                @(negedge clk);
                line_start = 1'b0;
                check("decoy_no_done", {31'b0, fetch_done}, 32'h0);
            end
        end
        next_y = 10'(ny);
        line_start = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) line_start = 1'b0;
            check("busy", {31'b0, busy}, {31'b0, (n <= 7)});
            check("fetch_done", {31'b0, fetch_done}, {31'b0, (n == 7)});
            if (n == 1) begin
                seen_addr[0] = rom_addr;
                check("addr_p", {24'b0, rom_addr}, {24'b0, model_addr(ny, py, 8'h00)});
            end
            if (n == 2) begin
                // Positions move mid-fetch; only the latched copies may matter.
                player_x = 10'($urandom); player_y = 10'($urandom);
                enemy_x = 10'($urandom);  enemy_y = 10'($urandom);
                bullet_x = 10'($urandom); bullet_y = 10'($urandom);
                enemy_en = 1'($urandom);  bullet_en = 1'($urandom);
                next_y = 10'($urandom);
            end
            if (n == 3) begin
                seen_addr[1] = rom_addr;
                check("addr_e", {24'b0, rom_addr}, {24'b0, model_addr(ny, ey, 8'h20)});
            end
            if (n == 5) begin
                seen_addr[2] = rom_addr;
                check("addr_b", {24'b0, rom_addr}, {24'b0, model_addr(ny, by, 8'h40)});
            end
        end
        lat_x[0] = px; lat_x[1] = ex; lat_x[2] = bx;
        mbuf[0] = model_row(ny, py, 32, 8'h00, 1'b1);
        mbuf[1] = model_row(ny, ey, 32, 8'h20, een);
        mbuf[2] = model_row(ny, by, 7, 8'h40, ben);
        model_valid = 1'b1;
    endtask

    task automatic sweep(input int x0, input int x1, input bit von);
        for (int x = x0; x <= x1; x++) begin
            @(negedge clk);
            pixel_x = 10'(x);
            video_on = von;
        end
        @(negedge clk);
        video_on = 1'b0;
    endtask

    task automatic probe(input string name, input int x, input logic [2:0] exp);
        @(negedge clk);
        pixel_x = 10'(x);
        video_on = 1'b1;
        @(negedge clk);
        check(name, {29'b0, pix_on}, {29'b0, exp});
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin lat_x[k] = 0; mbuf[k] = '0; end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_rom_addr", {24'b0, rom_addr}, 32'h0);
        check("rst_pix_on", {29'b0, pix_on}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_fetch_done", {31'b0, fetch_done}, 32'h0);
        reset = 1'b1;
        model_valid = 1'b1;
        sweep(0, 40, 1'b1);

        // Player fetch: row 15
        do_fetch(115, 300, 100, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        check("lit_addr_p_0F", {24'b0, seen_addr[0]}, 32'h0F);
        check("lit_rom_addr_hold", {24'b0, rom_addr}, {24'b0, seen_addr[2]});
        probe("lit_p_col0", 300, 3'b000);
        probe("lit_p_col6", 306, 3'b001);
        probe("lit_p_col25", 325, 3'b001);
        probe("lit_p_col26", 326, 3'b000);
        sweep(290, 340, 1'b1);
        sweep(295, 340, 1'b0);

        // Enemy pixels; player row negative, bullet disabled on top of the enemy
        do_fetch(50, 0, 400, 200, 50, 1'b1, 205, 50, 1'b0, 0, 0);
        check("lit_addr_e_20", {24'b0, seen_addr[1]}, 32'h20);
        probe("lit_e_211", 211, 3'b000);
        probe("lit_e_212", 212, 3'b010);
        probe("lit_e_214", 214, 3'b010);
        probe("lit_e_215", 215, 3'b000);
        probe("lit_e_217", 217, 3'b010);
        probe("lit_e_219", 219, 3'b010);
        probe("lit_e_220", 220, 3'b000);
        sweep(190, 240, 1'b1);

        // Bullet last row; enemy disabled at the same place
        do_fetch(306, 0, 600, 500, 306, 1'b0, 500, 300, 1'b1, 0, 0);
        check("lit_addr_b_46", {24'b0, seen_addr[2]}, 32'h46);
        probe("lit_b_514", 514, 3'b000);
        probe("lit_b_515", 515, 3'b100);
        probe("lit_b_516", 516, 3'b100);
        probe("lit_b_517", 517, 3'b000);
        sweep(490, 540, 1'b1);

        // Bullet one row past the end
        do_fetch(307, 0, 600, 500, 306, 1'b0, 500, 300, 1'b1, 0, 0);
        probe("lit_b_out_515", 515, 3'b000);
        sweep(490, 540, 1'b1);

        // Player one line above its top
        do_fetch(199, 100, 200, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        sweep(90, 140, 1'b1);

        // Right screen edge: no wrap into low columns
        do_fetch(12, 1010, 10, 0, 0, 1'b0, 0, 0, 1'b0, 0, 0);
        sweep(1000, 1023, 1'b1);
        sweep(0, 40, 1'b1);

        // Restart: second strobe 3 cycles after a decoy with a different next_y
        do_fetch(120, 400, 100, 600, 110, 1'b1, 700, 118, 1'b1, 3, 115);
        sweep(390, 440, 1'b1);
        sweep(590, 640, 1'b1);
        sweep(690, 740, 1'b1);

        // Reset two cycles after a strobe
        begin
            int c;
            c = 0;
            for (int i = 0; i < 32; i++) if (mbuf[0][31 - i]) begin c = i; break; end
            @(negedge clk);
            model_valid = 1'b0;
            pixel_x = 10'(lat_x[0] + c);
            video_on = 1'b1;
            player_x = 10'(lat_x[0]); player_y = 10'd100;
            enemy_en = 1'b0; bullet_en = 1'b0;
            next_y = 10'd120;
            line_start = 1'b1;
            @(negedge clk);
            line_start = 1'b0;
            @(negedge clk);
            check("pre_reset_pix", {31'b0, pix_on[0]}, {31'b0, mbuf[0] != 0});
            #2 reset = 1'b0;
            #1;
            check("mid_rst_busy", {31'b0, busy}, 32'h0);
            check("mid_rst_pix_on", {29'b0, pix_on}, 32'h0);
            check("mid_rst_rom_addr", {24'b0, rom_addr}, 32'h0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                check("post_rst_no_done", {31'b0, fetch_done}, 32'h0);
                check("post_rst_idle", {31'b0, busy}, 32'h0);
            end
            for (int k = 0; k < 3; k++) begin lat_x[k] = 0; mbuf[k] = '0; end
            model_valid = 1'b1;
            sweep(0, 60, 1'b1);
            sweep(390, 440, 1'b1);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
